// File: rtl/rom_arbiter_if.sv
// Requester/ROM-side bundle for rom_arbiter; master = requesters + ROM, slave = arbiter.
// Request, grant and response strobes travel together with the ROM address/data pair.
`timescale 1ns/1ps
interface rom_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [ADDR_WIDTH-1:0]         rom_addr;
    logic [DATA_WIDTH-1:0]         rom_data;

    modport master (
        output req_valid, req_addr, rom_data,
        input  req_ready, rsp_valid, rsp_data, rom_addr
    );

    modport slave (
        input  req_valid, req_addr, rom_data,
        output req_ready, rsp_valid, rsp_data, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter in front of a sync-read ROM; response 1 cycle after grant, one read/cycle.
// Backpressure: none on responses; ungranted requesters simply wait for req_ready.
`timescale 1ns/1ps
module rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    inflight_q, inflight_d;

    logic [NUM_REQ-1:0]    grant_raw;
    logic [PTR_W-1:0]      winner;
    logic                  found;
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] addr_mux;

    // Two passes give the wrapped scan order ptr..NUM_REQ-1 then 0..ptr-1.
    always_comb begin
        grant_raw = '0;
        winner    = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (PTR_W'(i) >= ptr_q) && bus.req_valid[i]) begin
                found        = 1'b1;
                winner       = PTR_W'(i);
                grant_raw[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (PTR_W'(i) < ptr_q) && bus.req_valid[i]) begin
                found        = 1'b1;
                winner       = PTR_W'(i);
                grant_raw[i] = 1'b1;
            end
        end
    end

    // Grants and the ROM address are combinational, so reset must mask them directly.
    always_comb begin
        grant     = rst_n ? grant_raw : '0;
        grant_any = rst_n & found;
    end

    always_comb begin
        addr_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                addr_mux = addr_mux | bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        inflight_d = grant;
        if (grant_any) begin
            ptr_d = (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rom_addr  = addr_mux;
    assign bus.rsp_valid = inflight_q;
    assign bus.rsp_data  = bus.rom_data;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_grant_valid:  assert property (@(posedge clk) disable iff (!rst_n) (grant & ~bus.req_valid) == '0);
    a_ptr_range:    assert property (@(posedge clk) disable iff (!rst_n) ptr_q <= LAST_IDX);
    a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(inflight_q));
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: vector table with a response scoreboard, plus reset corner sequences.
`timescale 1ns/1ps
module tb_rom_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] addrs;
        logic [N-1:0]    exp_ready;
    } vec_t;

    typedef struct {
        logic [N-1:0]  vld;
        logic [DW-1:0] dat;
    } rsp_t;

    logic   clk;
    logic   rst_n;
    int     checks;
    int     errors;
    rsp_t   sb_q[$];
    vec_t   vecs[18];
    logic [DW-1:0] rom_q;

    rom_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rom_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: registered address, mem[a] = a ^ 8'hA5.
    always_ff @(posedge clk) rom_q <= bus.rom_addr ^ 8'hA5;
    assign bus.rom_data = rom_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare mid-cycle, push the expected response for the next cycle.
    task automatic apply(input vec_t v);
        logic [AW-1:0] exp_addr;
        rsp_t          exp_rsp;
        rsp_t          nxt;
        bus.req_valid = v.valid;
        bus.req_addr  = v.addrs;
        exp_addr = '0;
        for (int i = 0; i < N; i++) begin
            if (v.exp_ready[i]) exp_addr = v.addrs[i*AW +: AW];
        end
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'(v.exp_ready));
        check("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
        if (sb_q.size() > 0) begin
            exp_rsp = sb_q.pop_front();
            check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp.vld));
            if (exp_rsp.vld != '0) check("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp.dat));
        end else begin
            check("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
        end
        nxt.vld = v.exp_ready;
        nxt.dat = exp_addr ^ 8'hA5;
        sb_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        // Full contention starting from ptr=0 after reset
        vecs[0]  = '{4'b1111, 32'h03020100, 4'b0001};
        vecs[1]  = '{4'b1111, 32'h03020100, 4'b0010};
        vecs[2]  = '{4'b1111, 32'h03020100, 4'b0100};
        vecs[3]  = '{4'b1111, 32'h03020100, 4'b1000};
        vecs[4]  = '{4'b1111, 32'h03020100, 4'b0001};
        // Lone requester 2: data B5, B4, B7
        vecs[5]  = '{4'b0100, 32'hEE10EEEE, 4'b0100};
        vecs[6]  = '{4'b0100, 32'hEE11EEEE, 4'b0100};
        vecs[7]  = '{4'b0100, 32'hEE12EEEE, 4'b0100};
        // ptr=3, reqs 1 and 3: grant 3, 1, 3
        vecs[8]  = '{4'b1010, 32'hC3EE41EE, 4'b1000};
        vecs[9]  = '{4'b1010, 32'hC3EE41EE, 4'b0010};
        vecs[10] = '{4'b1010, 32'hC3EE41EE, 4'b1000};
        // Idle gap: requests in cycles 0 and 3 only
        vecs[11] = '{4'b0001, 32'h5A5A5A77, 4'b0001};
        vecs[12] = '{4'b0000, 32'h11223344, 4'b0000};
        vecs[13] = '{4'b0000, 32'h11223344, 4'b0000};
        vecs[14] = '{4'b0001, 32'h5A5A5A78, 4'b0001};
        // ptr=1 with reqs 0 and 3: scan 1,2,3 picks 3, then ptr=0 picks 0
        vecs[15] = '{4'b1001, 32'h9900AAFF, 4'b1000};
        vecs[16] = '{4'b1001, 32'h9900AAFF, 4'b0001};
        vecs[17] = '{4'b0000, 32'h00000000, 4'b0000};

        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_addr  = 32'h03020100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 18; k++) apply(vecs[k]);

        // Mid-flight reset: grant req 1 at 0xFF, reset before the edge
        bus.req_valid = 4'b0010;
        bus.req_addr  = 32'h0000FF00;
        @(negedge clk);
        check("mid_grant", 32'(bus.req_ready), 32'b0010);
        check("mid_rom_addr", 32'(bus.rom_addr), 32'hFF);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("mid_ready_in_reset", 32'(bus.req_ready), 32'd0);
        check("mid_addr_in_reset", 32'(bus.rom_addr), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        // All valid after reset: requester 0 wins, proving ptr went back to 0
        v = '{4'b1111, 32'h03020100, 4'b0001};
        apply(v);

        // Asynchronous drop of a response already on the wire
        check("async_pre_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        check("async_pre_rsp_data", 32'(bus.rsp_data), 32'hA5);
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{4'b0000, 32'h00000000, 4'b0000};
        apply(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
